md_sequencer: RTL and testbench

Multiply/divide sequencer for the pipeline's execute stage. It owns the HI/LO register pair and runs the fixed-latency mult/multu/div/divu operations, handling mthi/mtlo as single-cycle writes. It drives the `busy` signal that the hazard unit stalls on. It cancels an operation on interrupt entry and restores HI/LO when an instruction is rolled back.

---
 rtl/mdu_pkg.sv | 26 ++
 rtl/md_arith.sv | 67 ++++++
 rtl/md_sequencer.sv | 143 ++++++++++++++
 tb/tb_md_sequencer.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mdu_pkg.sv
// Shared multiply/divide definitions: op encodings, default latencies and
// the sequencer state type. The decoder and hazard unit import the same constants.
package mdu_pkg;

  localparam logic [2:0] OP_NONE  = 3'd0;
  localparam logic [2:0] OP_MULT  = 3'd1;
  localparam logic [2:0] OP_MULTU = 3'd2;
  localparam logic [2:0] OP_DIV   = 3'd3;
  localparam logic [2:0] OP_DIVU  = 3'd4;
  localparam logic [2:0] OP_MTHI  = 3'd5;
  localparam logic [2:0] OP_MTLO  = 3'd6;

  localparam int unsigned MULT_CYCLES_DEF = 5;
  localparam int unsigned DIV_CYCLES_DEF  = 10;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } md_state_t;

  // True for the ops that occupy the unit for several cycles.
  function automatic logic is_arith_op(input logic [2:0] op);
    return (op == OP_MULT) || (op == OP_MULTU) || (op == OP_DIV) || (op == OP_DIVU);
  endfunction

endpackage

// File: rtl/md_arith.sv
// Combinational 64-bit product and quotient/remainder for the sequencer.
// res_valid is low when HI/LO must be left untouched (divide by zero, non-arith op).
module md_arith
  import mdu_pkg::*;
(
  input  logic [2:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] res_hi,
  output logic [31:0] res_lo,
  output logic        res_valid
);

  logic [63:0] prod_s;
  logic [63:0] prod_u;
  logic        signed_div;
  logic        a_neg;
  logic        b_neg;
  logic [31:0] mag_a;
  logic [31:0] mag_b;
  logic [31:0] safe_b;
  logic [31:0] q_mag;
  logic [31:0] r_mag;
  logic [31:0] quot;
  logic [31:0] rem;

  always_comb begin
    prod_s = {{32{a[31]}}, a} * {{32{b[31]}}, b};
    prod_u = {32'b0, a} * {32'b0, b};

    // Magnitude division keeps truncation toward zero explicit; the
    // 0x80000000 / -1 case falls out as q = 0x80000000, r = 0.
    signed_div = (op == OP_DIV);
    a_neg      = signed_div && a[31];
    b_neg      = signed_div && b[31];
    mag_a      = a_neg ? (32'd0 - a) : a;
    mag_b      = b_neg ? (32'd0 - b) : b;
    safe_b     = (mag_b == 32'd0) ? 32'd1 : mag_b;
    q_mag      = mag_a / safe_b;
    r_mag      = mag_a % safe_b;
    quot       = (a_neg ^ b_neg) ? (32'd0 - q_mag) : q_mag;
    rem        = a_neg ? (32'd0 - r_mag) : r_mag;

    res_hi    = 32'd0;
    res_lo    = 32'd0;
    res_valid = 1'b0;
    case (op)
      OP_MULT: begin
        res_hi    = prod_s[63:32];
        res_lo    = prod_s[31:0];
        res_valid = 1'b1;
      end
      OP_MULTU: begin
        res_hi    = prod_u[63:32];
        res_lo    = prod_u[31:0];
        res_valid = 1'b1;
      end
      OP_DIV, OP_DIVU: begin
        res_hi    = rem;
        res_lo    = quot;
        res_valid = (b != 32'd0);
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/md_sequencer.sv
// Multiply/divide sequencer: owns HI/LO, runs fixed-latency mult/div, handles
// mthi/mtlo, cancels on interrupt entry and restores HI/LO on rollback.
module md_sequencer
  import mdu_pkg::*;
#(
  parameter int unsigned MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int unsigned DIV_CYCLES  = DIV_CYCLES_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        int_req,
  input  logic        rollback,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam int unsigned MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CNT_W = $clog2(MAX_CYCLES) + 1;
  localparam logic [CNT_W-1:0] MULT_CNT = CNT_W'(MULT_CYCLES);
  localparam logic [CNT_W-1:0] DIV_CNT  = CNT_W'(DIV_CYCLES);

  // Handshake: start is a one-cycle strobe taken only in IDLE (busy low);
  // while busy is high every start is ignored until busy falls again.
  md_state_t        state, state_next;
  logic [CNT_W-1:0] cnt, cnt_next;
  logic [2:0]       op_q;
  logic [31:0]      a_q, b_q;
  logic [31:0]      snap_hi, snap_lo;
  logic             latch_en, snap_en, wr_hi, wr_lo, commit_en, restore_en;
  logic [31:0]      res_hi, res_lo;
  logic             res_valid;

  md_arith u_arith (
    .op        (op_q),
    .a         (a_q),
    .b         (b_q),
    .res_hi    (res_hi),
    .res_lo    (res_lo),
    .res_valid (res_valid)
  );

  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    latch_en   = 1'b0;
    snap_en    = 1'b0;
    wr_hi      = 1'b0;
    wr_lo      = 1'b0;
    commit_en  = 1'b0;
    restore_en = 1'b0;
    case (state)
      ST_IDLE: begin
        if (rollback) begin
          restore_en = 1'b1;
        end else if (!int_req && start) begin
          if (is_arith_op(op)) begin
            latch_en   = 1'b1;
            snap_en    = 1'b1;
            cnt_next   = ((op == OP_DIV) || (op == OP_DIVU)) ? DIV_CNT : MULT_CNT;
            state_next = ST_RUN;
          end else if (op == OP_MTHI) begin
            snap_en = 1'b1;
            wr_hi   = 1'b1;
          end else if (op == OP_MTLO) begin
            snap_en = 1'b1;
            wr_lo   = 1'b1;
          end
        end
      end
      ST_RUN: begin
        // Cancellation beats the commit even on the final cycle.
        if (rollback) begin
          restore_en = 1'b1;
          state_next = ST_IDLE;
          cnt_next   = '0;
        end else if (int_req) begin
          state_next = ST_IDLE;
          cnt_next   = '0;
        end else if (cnt == CNT_W'(1)) begin
          commit_en  = 1'b1;
          state_next = ST_IDLE;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt - CNT_W'(1);
        end
      end
      default: begin
        state_next = ST_IDLE;
        cnt_next   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_IDLE;
      cnt   <= '0;
      busy  <= 1'b0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
      busy  <= (state_next == ST_RUN);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      hi      <= 32'd0;
      lo      <= 32'd0;
      snap_hi <= 32'd0;
      snap_lo <= 32'd0;
      op_q    <= OP_NONE;
      a_q     <= 32'd0;
      b_q     <= 32'd0;
    end else begin
      if (latch_en) begin
        op_q <= op;
        a_q  <= a;
        b_q  <= b;
      end
      if (snap_en) begin
        snap_hi <= hi;
        snap_lo <= lo;
      end
      if (restore_en) begin
        hi <= snap_hi;
        lo <= snap_lo;
      end else if (commit_en && res_valid) begin
        hi <= res_hi;
        lo <= res_lo;
      end else begin
        if (wr_hi) hi <= a;
        if (wr_lo) lo <= a;
      end
    end
  end

endmodule

// File: tb/tb_md_sequencer.sv
// Bench for md_sequencer: directed scenarios then random traffic, checked
// per cycle against a behavioural model through an expected-value queue.
module tb_md_sequencer;
  import mdu_pkg::*;

  localparam int MC = 5;
  localparam int DC = 10;

  logic        clk = 1'b0;
  logic        reset, start, int_req, rollback;
  logic [2:0]  op;
  logic [31:0] a, b;
  logic        busy;
  logic [31:0] hi, lo;

  always #5 clk = ~clk;

  md_sequencer #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .op       (op),
    .a        (a),
    .b        (b),
    .int_req  (int_req),
    .rollback (rollback),
    .busy     (busy),
    .hi       (hi),
    .lo       (lo)
  );

  int          n_cmp = 0;
  int          n_fail = 0;
  int          cyc = 0;
  logic [64:0] exp_q[$];
  logic [64:0] mon_e;

  // Reference model state
  logic [31:0] m_hi = 0, m_lo = 0, s_hi = 0, s_lo = 0;
  logic [31:0] p_hi = 0, p_lo = 0;
  logic        p_ok = 0, m_run = 0;
  int          m_last = 0;

  task automatic compute(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
    longint      sx, sy, sp, q, r;
    logic [63:0] up;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    p_ok = 1'b1;
    p_hi = 0;
    p_lo = 0;
    case (o)
      OP_MULT: begin
        sp = sx * sy;
        p_hi = sp[63:32];
        p_lo = sp[31:0];
      end
      OP_MULTU: begin
        up = {32'd0, x} * {32'd0, y};
        p_hi = up[63:32];
        p_lo = up[31:0];
      end
      OP_DIV: begin
        if (y == 0) p_ok = 1'b0;
        else if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) begin
          p_lo = 32'h8000_0000;
          p_hi = 32'd0;
        end else begin
          q = sx / sy;
          r = sx % sy;
          p_lo = q[31:0];
          p_hi = r[31:0];
        end
      end
      default: begin
        if (y == 0) p_ok = 1'b0;
        else begin
          p_lo = x / y;
          p_hi = x % y;
        end
      end
    endcase
  endtask

  // Applies the rules for one clock edge using the inputs currently driven.
  task automatic model_edge();
    if (reset) begin
      m_hi = 0; m_lo = 0; s_hi = 0; s_lo = 0; m_run = 0;
    end else if (rollback) begin
      m_hi = s_hi; m_lo = s_lo; m_run = 0;
    end else if (int_req) begin
      m_run = 0;
    end else if (m_run) begin
      if (cyc == m_last) begin
        m_run = 0;
        if (p_ok) begin m_hi = p_hi; m_lo = p_lo; end
      end
    end else if (start) begin
      if (op >= 3'd1 && op <= 3'd4) begin
        s_hi = m_hi; s_lo = m_lo;
        compute(op, a, b);
        m_run = 1;
        m_last = cyc + ((op >= 3'd3) ? DC : MC);
      end else if (op == OP_MTHI) begin
        s_hi = m_hi; s_lo = m_lo; m_hi = a;
      end else if (op == OP_MTLO) begin
        s_hi = m_hi; s_lo = m_lo; m_lo = a;
      end
    end
    exp_q.push_back({m_run, m_hi, m_lo});
  endtask

  task automatic step(input logic rst, input logic st, input logic [2:0] o,
                      input logic [31:0] x, input logic [31:0] y,
                      input logic irq, input logic rb);
    reset = rst; start = st; op = o; a = x; b = y; int_req = irq; rollback = rb;
    model_edge();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 3'd0, $urandom, $urandom, 0, 0);
  endtask

  task automatic cmd(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
    step(0, 1, o, x, y, 0, 0);
  endtask

  task automatic expect_now(input string name, input logic eb,
                            input logic [31:0] eh, input logic [31:0] el);
    n_cmp++;
    if (busy !== eb || hi !== eh || lo !== el) begin
      n_fail++;
      $display("FAIL %s: got busy=%b hi=%h lo=%h, expected busy=%b hi=%h lo=%h",
               name, busy, hi, lo, eb, eh, el);
    end
  endtask

  function automatic logic [31:0] pick_val();
    case ($urandom_range(0, 5))
      0: return 32'd0;
      1: return 32'd1;
      2: return 32'hFFFF_FFFF;
      3: return 32'h8000_0000;
      4: return 32'h7FFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  // Monitor: every negedge the DUT presents busy/hi/lo for the last edge.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      n_cmp++;
      if ({busy, hi, lo} !== mon_e) begin
        n_fail++;
        $display("FAIL cycle_check t=%0t: got busy=%b hi=%h lo=%h, expected busy=%b hi=%h lo=%h",
                 $time, busy, hi, lo, mon_e[64], mon_e[63:32], mon_e[31:0]);
      end
    end
  end

  initial begin
    #1_000_000;
    n_fail++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    step(1, 0, 3'd0, 0, 0, 0, 0);
    step(1, 0, 3'd0, 0, 0, 0, 0);
    expect_now("reset_state", 0, 32'd0, 32'd0);

    cmd(OP_MULT, 32'hFFFF_FFFE, 32'd3);
    expect_now("mult_busy_t1", 1, 32'd0, 32'd0);
    idle(5);
    expect_now("mult_result", 0, 32'hFFFF_FFFF, 32'hFFFF_FFFA);

    cmd(OP_MULTU, 32'hFFFF_FFFF, 32'd2);
    idle(4);
    expect_now("multu_busy_t5", 1, 32'hFFFF_FFFF, 32'hFFFF_FFFA);
    idle(1);
    expect_now("multu_result", 0, 32'h0000_0001, 32'hFFFF_FFFE);

    cmd(OP_DIV, 32'hFFFF_FFF9, 32'd2);
    idle(10);
    expect_now("div_result", 0, 32'hFFFF_FFFF, 32'hFFFF_FFFD);

    cmd(OP_MTHI, 32'h11, 0);
    cmd(OP_MTLO, 32'h22, 0);
    cmd(OP_DIVU, 32'd5, 32'd0);
    idle(10);
    expect_now("divu_by_zero", 0, 32'h11, 32'h22);

    cmd(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
    idle(10);
    expect_now("div_overflow", 0, 32'd0, 32'h8000_0000);

    cmd(OP_MTHI, 32'hABCD, 0);
    expect_now("mthi_write", 0, 32'hABCD, 32'h8000_0000);
    step(0, 0, 3'd0, 0, 0, 0, 1);
    expect_now("rollback_restore", 0, 32'd0, 32'h8000_0000);

    cmd(OP_MULT, 32'd3, 32'd4);
    idle(2);
    step(0, 0, 3'd0, 0, 0, 1, 0);
    expect_now("int_cancel", 0, 32'd0, 32'h8000_0000);

    step(0, 1, OP_MULT, 32'd3, 32'd4, 1, 0);
    expect_now("start_with_int", 0, 32'd0, 32'h8000_0000);

    cmd(OP_DIV, 32'd100, 32'd7);
    idle(1);
    step(1, 0, 3'd0, 0, 0, 0, 0);
    expect_now("reset_mid_div", 0, 32'd0, 32'd0);

    // Back-to-back starts, with a stray start ignored mid-run.
    cmd(OP_MULT, 32'd6, 32'd7);
    idle(1);
    cmd(OP_MTHI, 32'hDEAD, 0);
    idle(3);
    cmd(OP_MULTU, 32'd2, 32'd3);
    expect_now("back_to_back", 1, 32'd0, 32'd42);
    idle(5);
    expect_now("back_to_back_result", 0, 32'd0, 32'd6);

    for (int i = 0; i < 2000; i++) begin
      step(($urandom_range(0, 299) == 0), ($urandom_range(0, 3) == 0),
           3'($urandom_range(0, 7)), pick_val(), pick_val(),
           ($urandom_range(0, 29) == 0), ($urandom_range(0, 39) == 0));
    end

    idle(2);
    @(negedge clk);
    #1;
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d entries left, expected 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
